// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch controller with show-ahead prefetch queue and redirect flush
module fetch_ctrl #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   QFULL  = (PW+1)'(DEPTH);
    localparam logic [29:0]   WLIMIT = 30'(IMEM_WORDS);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          fault;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic empty;
    logic out_of_range;
    logic pop;
    logic push;

    assign empty        = (count == '0);
    assign out_of_range = (fetch_pc[31:2] >= WLIMIT);
    assign pop          = ~empty & if_ready & ~redirect_valid;
    // A full queue may still accept a word in the same cycle its head is consumed.
    assign push         = ~redirect_valid & ~fault & ~out_of_range & ((count != QFULL) | pop);

    assign imem_addr   = fetch_pc;
    assign fetch_fault = fault;
    assign if_valid    = ~empty & ~redirect_valid;
    assign if_instr    = empty ? 32'h0 : q_instr[rd_ptr];
    assign if_pc       = empty ? 32'h0 : q_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= wr_ptr;
            count    <= '0;
            fault    <= |redirect_pc[1:0];
        end else begin
            if (out_of_range && !fault) begin
                fault <= 1'b1;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue payload needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_rd;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a queue-based reference model
module tb_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    logic [31:0] mem [WORDS];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_fault;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_ready       (if_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_rd = (imem_addr[31:2] < 30'(WORDS)) ? mem[imem_addr[7:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
    endtask

    // Compare against the model, advance the model by one cycle, then cross the clock edge.
    task automatic tick();
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_in;
        logic        popn;
        logic        oor;
        logic        pushn;
        e_v  = (mq.size() > 0) && !redirect_valid;
        e_pc = (mq.size() > 0) ? mq[0].pc : 32'h0;
        e_in = (mq.size() > 0) ? mq[0].instr : 32'h0;
        chk("model_if_valid", {31'h0, if_valid}, {31'h0, e_v});
        chk("model_if_pc", if_pc, e_pc);
        chk("model_if_instr", if_instr, e_in);
        chk("model_imem_addr", imem_addr, m_pc);
        chk("model_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
        if (reset) begin
            mq.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc    = redirect_pc;
            m_fault = (redirect_pc % 4) != 0;
        end else begin
            popn  = (mq.size() > 0) && if_ready;
            oor   = (m_pc / 4) >= WORDS;
            pushn = !m_fault && !oor && ((mq.size() < DEPTH) || popn);
            if (oor) m_fault = 1'b1;
            if (popn) void'(mq.pop_front());
            if (pushn) begin
                mq.push_back('{m_pc, mem[m_pc[7:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] stream_instr [3];
        logic        r;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;

        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0280_0813;
        mem[1] = 32'hFF40_0893;
        mem[2] = 32'h0280_0913;
        stream_instr[0] = 32'h0280_0813;
        stream_instr[1] = 32'hFF40_0893;
        stream_instr[2] = 32'h0280_0913;

        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
        chk("reset_valid", {31'h0, if_valid}, 32'h0);
        chk("reset_instr", if_instr, 32'h0);
        chk("reset_pc", if_pc, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_fault", {31'h0, fetch_fault}, 32'h0);

        // Streaming
        drive(0, 0, 0, 1);
        chk("stream_c0_valid", {31'h0, if_valid}, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1);
            chk("stream_valid", {31'h0, if_valid}, 32'h1);
            chk("stream_pc", if_pc, 32'(4 * k));
            chk("stream_instr", if_instr, stream_instr[k]);
            tick();
        end

        // Back-pressure, then full + pop
        drive(1, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0);
        chk("bp_hold_addr", imem_addr, 32'h10);
        chk("bp_head_pc", if_pc, 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1);
            chk("bp_release_pc", if_pc, 32'(4 * k));
            if (k == 1) chk("full_pop_addr", imem_addr, 32'h14);
            tick();
        end

        // Redirect mid-stream with pcs 8..20 queued
        drive(1, 0, 0, 0); tick();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0); tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1); tick();
        end
        drive(0, 0, 0, 1);
        chk("redir_pre_pc", if_pc, 32'h8);
        drive(0, 1, 32'h64, 1);
        chk("redir_cycle_valid", {31'h0, if_valid}, 32'h0);
        tick();
        drive(0, 0, 0, 1);
        chk("redir_n1_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_n1_addr", imem_addr, 32'h64);
        tick();
        drive(0, 0, 0, 1);
        chk("redir_n2_pc", if_pc, 32'h64);
        chk("redir_n2_instr", if_instr, mem[25]);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1); tick();
        end

        // Out-of-range at the top of memory, then recovery
        drive(0, 1, 32'hF8, 1); tick();
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 1);
        chk("oor_w62_pc", if_pc, 32'hF8);
        chk("oor_w62_instr", if_instr, mem[62]);
        tick();
        drive(0, 0, 0, 1);
        chk("oor_w63_pc", if_pc, 32'hFC);
        chk("oor_w63_instr", if_instr, mem[63]);
        chk("oor_addr", imem_addr, 32'h100);
        tick();
        drive(0, 0, 0, 1);
        chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
        chk("oor_valid", {31'h0, if_valid}, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1);
            chk("oor_halt_addr", imem_addr, 32'h100);
            tick();
        end
        drive(0, 1, 32'h0, 1); tick();
        drive(0, 0, 0, 1);
        chk("recover_fault", {31'h0, fetch_fault}, 32'h0);
        tick();
        drive(0, 0, 0, 1);
        chk("recover_pc", if_pc, 32'h0);
        chk("recover_valid", {31'h0, if_valid}, 32'h1);
        tick();

        // Misaligned redirect
        drive(0, 1, 32'h66, 1); tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1);
            chk("misalign_fault", {31'h0, fetch_fault}, 32'h1);
            chk("misalign_valid", {31'h0, if_valid}, 32'h0);
            chk("misalign_addr", imem_addr, 32'h66);
            tick();
        end

        // Reset with a full queue
        drive(0, 1, 32'h0, 0); tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0); tick();
        end
        drive(1, 1, 32'h40, 1); tick();
        drive(0, 0, 0, 1);
        chk("rst_mid_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_mid_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_mid_addr", imem_addr, 32'h0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom % 64) == 0;
            rv  = ($urandom % 12) == 0;
            if (($urandom % 8) == 0) rpc = 32'($urandom_range(0, 300));
            else                     rpc = 32'($urandom_range(0, 70)) << 2;
            rdy = ($urandom % 4) != 0;
            drive(r, rv, rpc, rdy);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the IF stage: owns the fetch PC and drives the word-addressed, combinational-read instruction memory.
- Buffers fetched words in a small prefetch queue, so decode stalls do not stall the memory.
- Services branch/jump redirects from EX by flushing the queue and restarting fetch at the new PC.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- IMEM_WORDS, 64, number of valid instruction words; fetch PC word index ≥ IMEM_WORDS is out of range.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc.
- imem_rd  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  EX requests a control-flow change this cycle.
- redirect_pc  in  32  target byte address; sampled when redirect_valid=1.
- if_ready  in  1  decode accepts the head entry this cycle.
- if_valid  out  1  head entry valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  PC of head instruction.
- fetch_fault  out  1  fetch halted: misaligned redirect target or fetch PC out of range.

Behaviour:
- Reset (sync, takes priority over everything):
  - fetch_pc ← RESET_PC; queue emptied (rd_ptr = wr_ptr = 0, count = 0); fetch_fault ← 0.
  - if_valid = 0, if_instr = 0, if_pc = 0 while the queue is empty.
- imem_addr = fetch_pc at all times (combinational from register).
- Queue behaviour:
  - Show-ahead: if_valid = (count ≠ 0); if_instr and if_pc come from the rd_ptr entry.
  - When empty, if_instr and if_pc are driven to 0.
- pop = if_valid & if_ready & ~redirect_valid.
- push = ~redirect_valid & ~fetch_fault & (count < DEPTH | pop).
  - Push stores {fetch_pc, imem_rd} at wr_ptr.
  - Push advances fetch_pc by 4; the adder wraps modulo 2^32.
- Full queue with simultaneous pop: push is allowed; count is unchanged.
- Empty queue with if_ready=1: no pop; count stays 0.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Redirect (redirect_valid=1, no reset):
  - All queue entries are flushed: count ← 0, rd_ptr ← wr_ptr.
  - if_valid is forced to 0 in that cycle, so decode never consumes a squashed entry.
  - fetch_pc ← redirect_pc; no push and no pop that cycle.
  - If redirect_pc[1:0] ≠ 0, fetch_fault ← 1; otherwise fetch_fault ← 0.
- Out-of-range fetch:
  - If fetch_pc[31:2] ≥ IMEM_WORDS and fetch_fault = 0 and no redirect: fetch_fault ← 1, no push.
  - Already-queued entries still drain normally.
  - fetch_fault clears only on reset or on an aligned redirect.
- Latency:
  - Redirect in cycle N: first new push in N+1; if_valid = 1 with if_pc = target in N+2.
  - After reset deasserts in cycle 0: push in cycle 0, if_valid in cycle 1.
- Throughput: with if_ready held at 1, one instruction per cycle sustained, with no bubbles.
- Redirect and reset in the same cycle: reset wins.
- Redirect while the queue is full: the flush takes effect; the queue is not refilled in that cycle.

Test Plan:
- Streaming: memory word0 = 32'h02800813, word1 = 32'hFF400893, word2 = 32'h02800913; reset, if_ready=1 → cycles 1, 2, 3 present (pc, instr) = (0, 02800813), (4, FF400893), (8, 02800913); no bubbles.
- Back-pressure:
  - Stimulus: if_ready=0 for 8 cycles after reset, then if_ready=1.
  - Fill: count saturates at 4; fetch_pc holds at 16 (0x10).
  - Release: pcs 0, 4, 8, 12, 16 in consecutive cycles; no drops or duplicates.
- Redirect mid-stream:
  - Stimulus: queue holding pcs 8..20; assert redirect_valid with redirect_pc=0x64 for one cycle.
  - Redirect cycle: if_valid = 0.
  - Two cycles later: if_pc = 0x64, with instr = memory word 25.
  - Stale pcs 8..20 never appear on the outputs.
- Full + pop simultaneous: queue full, if_ready=1 for one cycle → count stays 4; fetch_pc advances by 4; the popped entry is the oldest one.
- Out-of-range:
  - Stimulus: redirect_pc = 0xF8 (word 62); if_ready=1.
  - Outputs: words 62 and 63 delivered.
  - Fault: fetch_fault = 1 once fetch_pc = 0x100; no further pushes.
  - Recovery: a later redirect to 0x0 clears the fault and fetch resumes.
- Misaligned / reset mid-operation:
  - Misaligned: redirect_pc = 0x66 → fetch_fault = 1; if_valid stays 0.
  - Reset mid-operation: reset asserted mid-stream with a full queue → next cycle if_valid = 0, fetch_fault = 0, imem_addr = 0.
